tomasulo_dispatcher_param: RTL and testbench
============================================

# tomasulo_dispatcher_param

Parametrised dispatch stage for the Tomasulo core. It renames destination registers to tags, resolves operands from the register file, the tag table or a same-cycle CDB bypass, and steers each instruction to one reservation station (RS) in its functional-unit class. It sits between the instruction FIFO and the RS array, with the ROB outside the block.

Over the fixed-width dispatcher it adds:
- configurable register, tag, class and RS counts;
- tag-matched CDB retirement, so a stale producer never clears a re-renamed register;
- a synchronous flush.

## Interface
Parameters:
- REG_N, 32, architectural registers; RA_W = $clog2(REG_N).
- TAG_N, 16, rename tags in flight; TAG_W = $clog2(TAG_N).
- WORD_W, 32, data width.
- CLS_N, 3, functional-unit classes.
- RS_PER_CLS, 2, RS per class; RS_N = CLS_N*RS_PER_CLS; RS index = cls*RS_PER_CLS + slot.
- ROBID_W, 5, ROB id width.
- OP_W, 4, opcode width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- inst_vld  in  1  instruction valid.
- inst_op  in  OP_W  opcode.
- inst_cls  in  $clog2(CLS_N)  class index.
- inst_ra  in  2xRA_W  source registers [1:0].
- inst_wa  in  RA_W  destination register.
- inst_imm  in  WORD_W  immediate.
- inst_adv  out  1  instruction consumed this cycle (combinational).
- rs_full_r  in  RS_N  per-RS full; the RS array accounts for the previous cycle's dispatch.
- rob_alloc_rdy  in  1  ROB has space.
- rob_alloc_id  in  ROBID_W  id granted on allocation.
- rob_alloc_vld  out  1  = inst_adv.
- cdb_vld  in  1  CDB valid.
- cdb_wa  in  RA_W  CDB destination register.
- cdb_tag  in  TAG_W  CDB tag.
- cdb_wdata  in  WORD_W  CDB data.
- flush  in  1  discard all in-flight rename state.
- dis_vld_r  out  RS_N  one-hot dispatch strobe.
- dis_r  out  struct  {op, tag, robid, opr[1:0]{busy, tag, word}, imm}.
- idle_r  out  1  all tags free.

## Operation
- **Dispatch condition (emit):** inst_vld & !flush & rob_alloc_rdy & any free tag & some non-full RS in class inst_cls.
  - inst_adv = emit.
- **Target RS:** lowest-index non-full RS within class inst_cls.
- **Tag allocation:** lowest-index free tag, taken from registered free-list state. A tag freed this cycle is not reallocated until the next cycle.
- **Operand resolution, per source i:**
  - not busy[ra] -> word = regfile[ra];
  - busy & cdb_vld & cdb_tag == tag_tbl[ra] -> word = cdb_wdata;
  - otherwise -> busy = 1, tag = tag_tbl[ra].
  - Unused fields are zero.
- **Rename on emit:** busy[wa] <= 1, tag_tbl[wa] <= new tag.
- **CDB handling:**
  - cdb_tag is always freed.
  - regfile[cdb_wa] <= cdb_wdata always.
  - busy[cdb_wa] is cleared only if busy[cdb_wa] & tag_tbl[cdb_wa] == cdb_tag.
- **Same-cycle CDB clear and emit to the same register:** the emit wins; busy stays 1 with the new tag.
- **Operand equal to own destination (ra == wa):** the operand reads pre-rename state.
- **Flush:**
  - next cycle: busy table all 0, all tags free, dis_vld_r 0;
  - CDB in the flush cycle is ignored entirely;
  - no emit in the flush cycle.
- **Free-list integrity:** a CDB free of an already-free tag is an error. It raises an assertion; no state change.

## Timing
- Emit in cycle N -> dis_vld_r / dis_r valid in cycle N+1 for exactly one cycle.
- dis_r holds its value when there is no emit.
- inst_adv and rob_alloc_vld are combinational in cycle N; rob_alloc_id is sampled in N.
- CDB in cycle N is visible to register reads in N via bypass and via the flops from N+1.
- A tag freed in cycle N is allocatable from N+1.
- Reset values:
  - dis_vld_r 0, dis_r 0;
  - busy all 0, tag table 0, regfile 0;
  - all tags free, idle_r 1.
- idle_r is registered, and is 1 when the free list is full after the edge.
- Reset mid-operation drops all in-flight state identically to a flush, plus clears the regfile.

## Structure
- tomasulo_pkg:
  - default parameter constants;
  - class enum (ARITH, LOGIC, MPY);
  - the oprand_t / dispatch_t typedefs, parametrised through localparams in this block.
- Sub-module tomasulo_tag_pool:
  - TAG_N-bit free vector, lowest-free find-first;
  - alloc/free/flush ports, empty/full flags;
  - async active-low reset.
- The busy table, tag table and regfile are flop arrays local to this block.

## Test plan
- **Reset then idle:** r1 = 0 -> idle_r = 1. Dispatch ADD r3 <- r1, r2 -> dis_vld_r = 0b000001, tag 0, both operands non-busy with word 0.
- **Dependency chain:**
  - I0 writes r3 (tag 0), then I1 reads r3 -> I1 opr0 busy, tag 0.
  - CDB {r3, tag 0, 0xA5} during I2 dispatch reading r3 -> I2 opr0 word 0xA5, not busy.
- **Stale producer:**
  - r5 renamed to tag 0, then re-renamed to tag 1.
  - CDB tag 0 -> busy[r5] stays 1, tag 1; a later reader of r5 gets tag 1.
- **Backpressure:**
  - both ARITH RS full -> inst_adv = 0, no dis_vld_r; a LOGIC instruction still dispatches to RS 2.
  - with all TAG_N tags allocated -> stall until a CDB free, dispatch resumes next cycle with that tag.
- **Flush and collision:**
  - flush with 5 tags in flight -> next cycle idle_r = 1, busy all 0.
  - same-cycle CDB clear and dispatch to r7 -> busy[r7] = 1 with the new tag.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared constants and types for the Tomasulo dispatch slice.
// Class enum plus operand / dispatch bundle typedefs.
package tomasulo_pkg;

  localparam int REG_N_D      = 32;
  localparam int TAG_N_D      = 16;
  localparam int WORD_W_D     = 32;
  localparam int CLS_N_D      = 3;
  localparam int RS_PER_CLS_D = 2;
  localparam int ROBID_W_D    = 5;
  localparam int OP_W_D       = 4;
  localparam int TAG_W_D      = $clog2(TAG_N_D);

  typedef enum logic [1:0] {
    ARITH = 2'd0,
    LOGIC = 2'd1,
    MPY   = 2'd2
  } cls_e;

  typedef struct packed {
    logic                busy;
    logic [TAG_W_D-1:0]  tag;
    logic [WORD_W_D-1:0] word;
  } oprand_t;

  typedef struct packed {
    logic [OP_W_D-1:0]    op;
    logic [TAG_W_D-1:0]   tag;
    logic [ROBID_W_D-1:0] robid;
    oprand_t [1:0]        opr;
    logic [WORD_W_D-1:0]  imm;
  } dispatch_t;

endpackage

// File: rtl/tomasulo_tag_pool.sv
// Rename-tag free list: lowest-free pick, alloc/free/flush.
// Ports: alloc_i/alloc_tag_o, free_i/free_tag_i, flush_i, empty_o, full_o.
module tomasulo_tag_pool
  import tomasulo_pkg::*;
#(
  parameter int TAG_N = TAG_N_D,
  localparam int TAG_W = $clog2(TAG_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_i,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  input  logic             flush_i,
  output logic [TAG_W-1:0] alloc_tag_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [TAG_N-1:0] free_q, free_d;

  always_comb begin
    alloc_tag_o = '0;
    for (int t = TAG_N-1; t >= 0; t--)
      if (free_q[t]) alloc_tag_o = TAG_W'(t);
  end

  assign empty_o = ~|free_q;
  assign full_o  = &free_q;

  // A tag freed this cycle only becomes pickable next cycle,
  // since the pick reads free_q, not free_d.
  always_comb begin
    free_d = free_q;
    if (flush_i) begin
      free_d = '1;
    end else begin
      if (alloc_i) free_d[alloc_tag_o] = 1'b0;
      if (free_i)  free_d[free_tag_i]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) free_q <= '1;
    else        free_q <= free_d;

  a_no_dbl_free: assert property (
    @(posedge clk) disable iff (!rst_n)
    (free_i && !flush_i) |-> !free_q[free_tag_i]
  );

endmodule

// File: rtl/tomasulo_dispatcher_param.sv
// Dispatch stage: rename, operand resolve with CDB bypass, RS steer.
// Ports: inst_* in, rs_full_r/rob_* handshake, cdb_*, flush, dis_* out.
module tomasulo_dispatcher_param
  import tomasulo_pkg::*;
#(
  parameter int REG_N      = REG_N_D,
  parameter int TAG_N      = TAG_N_D,
  parameter int WORD_W     = WORD_W_D,
  parameter int CLS_N      = CLS_N_D,
  parameter int RS_PER_CLS = RS_PER_CLS_D,
  parameter int ROBID_W    = ROBID_W_D,
  parameter int OP_W       = OP_W_D,
  localparam int RA_W  = $clog2(REG_N),
  localparam int TAG_W = $clog2(TAG_N),
  localparam int CLS_W = $clog2(CLS_N),
  localparam int RS_N  = CLS_N * RS_PER_CLS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_vld,
  input  logic [OP_W-1:0]      inst_op,
  input  logic [CLS_W-1:0]     inst_cls,
  input  logic [1:0][RA_W-1:0] inst_ra,
  input  logic [RA_W-1:0]      inst_wa,
  input  logic [WORD_W-1:0]    inst_imm,
  output logic                 inst_adv,
  input  logic [RS_N-1:0]      rs_full_r,
  input  logic                 rob_alloc_rdy,
  input  logic [ROBID_W-1:0]   rob_alloc_id,
  output logic                 rob_alloc_vld,
  input  logic                 cdb_vld,
  input  logic [RA_W-1:0]      cdb_wa,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [WORD_W-1:0]    cdb_wdata,
  input  logic                 flush,
  output logic [RS_N-1:0]      dis_vld_r,
  output dispatch_t            dis_r,
  output logic                 idle_r
);

  logic [REG_N-1:0]  busy_q;
  logic [TAG_W-1:0]  ttbl_q [REG_N];
  logic [WORD_W-1:0] rf_q   [REG_N];

  logic [RS_N-1:0]  rs_oh, dis_vld_d;
  logic             rs_ok, emit, cdb_hit;
  logic             tag_empty;
  logic [TAG_W-1:0] new_tag;
  dispatch_t        dis_q, dis_d;

  tomasulo_tag_pool #(.TAG_N(TAG_N)) u_pool (
    .clk        (clk),
    .rst_n      (rst),
    .alloc_i    (emit),
    .free_i     (cdb_vld),
    .free_tag_i (cdb_tag),
    .flush_i    (flush),
    .alloc_tag_o(new_tag),
    .empty_o    (tag_empty),
    .full_o     (idle_r)
  );

  // Lowest non-full RS within the requested class.
  always_comb begin
    rs_oh = '0;
    rs_ok = 1'b0;
    for (int r = 0; r < RS_N; r++)
      if (!rs_ok && (r / RS_PER_CLS) == int'(inst_cls)
          && !rs_full_r[r]) begin
        rs_oh[r] = 1'b1;
        rs_ok    = 1'b1;
      end
  end

  assign emit = inst_vld & ~flush & rob_alloc_rdy
              & ~tag_empty & rs_ok;
  assign inst_adv      = emit;
  assign rob_alloc_vld = emit;

  assign dis_vld_d = emit ? rs_oh : '0;

  always_comb begin
    dis_d = dis_q;
    if (emit) begin
      dis_d.op    = inst_op;
      dis_d.tag   = new_tag;
      dis_d.robid = rob_alloc_id;
      dis_d.imm   = inst_imm;
      for (int i = 0; i < 2; i++) begin
        dis_d.opr[i] = '0;
        if (!busy_q[inst_ra[i]])
          dis_d.opr[i].word = rf_q[inst_ra[i]];
        else if (cdb_vld && cdb_tag == ttbl_q[inst_ra[i]])
          dis_d.opr[i].word = cdb_wdata;
        else begin
          dis_d.opr[i].busy = 1'b1;
          dis_d.opr[i].tag  = ttbl_q[inst_ra[i]];
        end
      end
    end
  end

  // Only the current producer may clear busy.
  assign cdb_hit = busy_q[cdb_wa] & (ttbl_q[cdb_wa] == cdb_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      for (int r = 0; r < REG_N; r++) begin
        ttbl_q[r] <= '0;
        rf_q[r]   <= '0;
      end
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      if (cdb_vld) begin
        rf_q[cdb_wa] <= cdb_wdata;
        if (cdb_hit) busy_q[cdb_wa] <= 1'b0;
      end
      // Later assignment: a same-cycle rename beats the clear.
      if (emit) begin
        busy_q[inst_wa] <= 1'b1;
        ttbl_q[inst_wa] <= new_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dis_vld_r <= '0;
      dis_q     <= '0;
    end else begin
      dis_vld_r <= dis_vld_d;
      dis_q     <= dis_d;
    end
  end

  assign dis_r = dis_q;

endmodule

// File: tb/tb_tomasulo_dispatcher_param.sv
// Directed bench for tomasulo_dispatcher_param.
// Hand-computed expectations for rename, bypass, stall and flush.
module tb_tomasulo_dispatcher_param;
  import tomasulo_pkg::*;

  logic            clk, rst;
  logic            inst_vld;
  logic [3:0]      inst_op;
  logic [1:0]      inst_cls;
  logic [1:0][4:0] inst_ra;
  logic [4:0]      inst_wa;
  logic [31:0]     inst_imm;
  logic            inst_adv;
  logic [5:0]      rs_full_r;
  logic            rob_alloc_rdy;
  logic [4:0]      rob_alloc_id;
  logic            rob_alloc_vld;
  logic            cdb_vld;
  logic [4:0]      cdb_wa;
  logic [3:0]      cdb_tag;
  logic [31:0]     cdb_wdata;
  logic            flush;
  logic [5:0]      dis_vld_r;
  dispatch_t       dis_r;
  logic            idle_r;

  int total = 0;
  int bad   = 0;

  tomasulo_dispatcher_param dut (
    .clk          (clk),
    .rst          (rst),
    .inst_vld     (inst_vld),
    .inst_op      (inst_op),
    .inst_cls     (inst_cls),
    .inst_ra      (inst_ra),
    .inst_wa      (inst_wa),
    .inst_imm     (inst_imm),
    .inst_adv     (inst_adv),
    .rs_full_r    (rs_full_r),
    .rob_alloc_rdy(rob_alloc_rdy),
    .rob_alloc_id (rob_alloc_id),
    .rob_alloc_vld(rob_alloc_vld),
    .cdb_vld      (cdb_vld),
    .cdb_wa       (cdb_wa),
    .cdb_tag      (cdb_tag),
    .cdb_wdata    (cdb_wdata),
    .flush        (flush),
    .dis_vld_r    (dis_vld_r),
    .dis_r        (dis_r),
    .idle_r       (idle_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [63:0] got,
                          logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [1:0] cls,
                       input logic [4:0] ra0,
                       input logic [4:0] ra1,
                       input logic [4:0] wa,
                       input logic [31:0] imm);
    inst_vld   = 1'b1;
    inst_op    = op;
    inst_cls   = cls;
    inst_ra[0] = ra0;
    inst_ra[1] = ra1;
    inst_wa    = wa;
    inst_imm   = imm;
  endtask

  task automatic cdb(input logic [4:0] wa,
                     input logic [3:0] tag,
                     input logic [31:0] data);
    cdb_vld   = 1'b1;
    cdb_wa    = wa;
    cdb_tag   = tag;
    cdb_wdata = data;
  endtask

  initial begin
    rst = 1'b0;
    inst_vld = 0; inst_op = 0; inst_cls = 0;
    inst_ra = '0; inst_wa = 0; inst_imm = 0;
    rs_full_r = '0; rob_alloc_rdy = 1'b1;
    rob_alloc_id = 0; flush = 0;
    cdb_vld = 0; cdb_wa = 0; cdb_tag = 0; cdb_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_idle", idle_r, 1);
    check_eq("rst_vld", dis_vld_r, 0);
    check_eq("rst_dis", dis_r, 0);
    rst = 1'b1;
    step();

    // ADD r3 <- r1, r2
    drive(4'h1, ARITH, 5'd1, 5'd2, 5'd3, 32'h10);
    rob_alloc_id = 5'd7;
    #1;
    check_eq("add_adv", inst_adv, 1);
    check_eq("add_rob", rob_alloc_vld, 1);
    step();
    inst_vld = 0;
    check_eq("add_vld", dis_vld_r, 6'b000001);
    check_eq("add_tag", dis_r.tag, 0);
    check_eq("add_op", dis_r.op, 4'h1);
    check_eq("add_robid", dis_r.robid, 7);
    check_eq("add_imm", dis_r.imm, 32'h10);
    check_eq("add_o0", dis_r.opr[0], 0);
    check_eq("add_o1", dis_r.opr[1], 0);
    check_eq("add_idle", idle_r, 0);

    // I1 reads r3 -> waits on tag 0
    drive(4'h2, ARITH, 5'd3, 5'd0, 5'd4, 0);
    step();
    inst_vld = 0;
    check_eq("i1_busy", dis_r.opr[0].busy, 1);
    check_eq("i1_otag", dis_r.opr[0].tag, 0);
    check_eq("i1_tag", dis_r.tag, 1);

    // I2 reads r3 with same-cycle CDB bypass
    drive(4'h3, ARITH, 5'd3, 5'd3, 5'd6, 0);
    cdb(5'd3, 4'd0, 32'hA5);
    step();
    inst_vld = 0; cdb_vld = 0;
    check_eq("i2_o0", dis_r.opr[0], {1'b0, 4'd0, 32'hA5});
    check_eq("i2_o1", dis_r.opr[1], {1'b0, 4'd0, 32'hA5});
    check_eq("i2_tag", dis_r.tag, 2);

    // I3: r3 from regfile, r4 still pending, tag 0 reused
    drive(4'h4, ARITH, 5'd3, 5'd4, 5'd8, 0);
    step();
    check_eq("i3_o0", dis_r.opr[0], {1'b0, 4'd0, 32'hA5});
    check_eq("i3_o1", dis_r.opr[1], {1'b1, 4'd1, 32'h0});
    check_eq("i3_tag", dis_r.tag, 0);
    drive(4'h4, ARITH, 5'd0, 5'd0, 5'd9, 0);
    step();
    drive(4'h4, ARITH, 5'd0, 5'd0, 5'd10, 0);
    step();
    inst_vld = 0;
    check_eq("i5_tag", dis_r.tag, 4);

    // Flush with 5 tags in flight; CDB that cycle is ignored
    drive(4'h5, ARITH, 5'd1, 5'd2, 5'd11, 0);
    flush = 1'b1;
    cdb(5'd4, 4'd1, 32'h77);
    #1;
    check_eq("fl_adv", inst_adv, 0);
    step();
    flush = 0; cdb_vld = 0; inst_vld = 0;
    check_eq("fl_idle", idle_r, 1);
    check_eq("fl_vld", dis_vld_r, 0);

    drive(4'h6, ARITH, 5'd3, 5'd4, 5'd5, 0);
    step();
    check_eq("pf_o0", dis_r.opr[0], {1'b0, 4'd0, 32'hA5});
    check_eq("pf_o1", dis_r.opr[1], 0);
    check_eq("pf_tag", dis_r.tag, 0);

    // Stale producer: r5 re-renamed to tag 1, then CDB tag 0
    drive(4'h7, ARITH, 5'd0, 5'd0, 5'd5, 0);
    step();
    inst_vld = 0;
    check_eq("rr_tag", dis_r.tag, 1);
    cdb(5'd5, 4'd0, 32'h11);
    step();
    cdb_vld = 0;
    drive(4'h8, ARITH, 5'd5, 5'd0, 5'd11, 0);
    step();
    inst_vld = 0;
    check_eq("st_o0", dis_r.opr[0], {1'b1, 4'd1, 32'h0});
    check_eq("st_tag", dis_r.tag, 0);

    // Backpressure: both ARITH RS full
    rs_full_r = 6'b000011;
    drive(4'h9, ARITH, 5'd0, 5'd0, 5'd12, 0);
    #1;
    check_eq("bp_adv", inst_adv, 0);
    step();
    check_eq("bp_vld", dis_vld_r, 0);
    check_eq("bp_hold", dis_r.tag, 0);
    drive(4'hA, LOGIC, 5'd0, 5'd0, 5'd12, 0);
    #1;
    check_eq("lg_adv", inst_adv, 1);
    step();
    check_eq("lg_vld", dis_vld_r, 6'b000100);
    check_eq("lg_tag", dis_r.tag, 2);
    rs_full_r = '0;

    // Exhaust tags 3..15
    for (int k = 0; k < 13; k++) begin
      drive(4'h1, LOGIC, 5'd0, 5'd0, 5'(13 + k), 0);
      step();
    end
    check_eq("fill_tag", dis_r.tag, 15);
    drive(4'h1, ARITH, 5'd0, 5'd0, 5'd30, 0);
    #1;
    check_eq("ex_adv", inst_adv, 0);
    step();
    check_eq("ex_vld", dis_vld_r, 0);
    cdb(5'd19, 4'd9, 32'h0);
    #1;
    check_eq("ex_free_adv", inst_adv, 0);
    step();
    cdb_vld = 0;
    #1;
    check_eq("ex_res_adv", inst_adv, 1);
    step();
    inst_vld = 0;
    check_eq("ex_res_tag", dis_r.tag, 9);
    check_eq("ex_res_vld", dis_vld_r, 6'b000001);

    // Second flush, then CDB clear vs rename collision on r7
    flush = 1'b1;
    step();
    flush = 0;
    check_eq("fl2_idle", idle_r, 1);
    drive(4'h2, ARITH, 5'd0, 5'd0, 5'd7, 0);
    step();
    drive(4'h3, ARITH, 5'd0, 5'd0, 5'd7, 0);
    cdb(5'd7, 4'd0, 32'h33);
    step();
    cdb_vld = 0;
    check_eq("col_tag", dis_r.tag, 1);
    drive(4'h4, ARITH, 5'd7, 5'd0, 5'd1, 0);
    step();
    inst_vld = 0;
    check_eq("col_o0", dis_r.opr[0], {1'b1, 4'd1, 32'h0});
    check_eq("col_rtag", dis_r.tag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
